cu_cmd_issuer: RTL and testbench

- Sequential command issuer that drives the control-field inputs of the combinational control-unit decoder (a, b, c, d, e, f, o).
- Accepts queued commands over a valid/ready interface and encodes each into a control word.
- Holds the word stable and, for select commands, waits for the decoder's one-hot select strobe to come back before retiring.
- It is the sending end of the decoder's control interface.

---
 rtl/cu_issue_pkg.sv | 49 ++++
 rtl/cu_cmd_issuer_if.sv | 27 ++
 rtl/cu_issue_fifo.sv | 53 +++++
 rtl/cu_cmd_issuer.sv | 149 ++++++++++++++
 tb/tb_cu_cmd_issuer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cu_issue_pkg.sv
// Shared types for the control-unit command issuer: opcodes, FSM states,
// the 7-bit control word {a,b,c,d,e,f,o}, the queued command record and the word encoder.
package cu_issue_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_SEL  = 2'd1,
        OP_PASS = 2'd2,
        OP_GATE = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
        logic e;
        logic f;
        logic o;
    } ctl_word_t;

    typedef struct packed {
        op_e        op;
        logic [1:0] sel;
        logic       mode;
    } cmd_t;

    // d=1 suppresses every decoder strobe, so this is the safe resting word.
    localparam ctl_word_t IDLE_WORD = 7'b0001000;

    function automatic ctl_word_t encode(input op_e op, input logic [1:0] sel, input logic mode);
        ctl_word_t w;
        case (op)
            OP_SEL:  w = {sel[0], sel[1], 5'b00010};
            OP_PASS: w = {4'b0010, 1'b1, 1'b0, mode};
            OP_GATE: w = 7'b0000111;
            default: w = IDLE_WORD;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/cu_cmd_issuer_if.sv
// Command queue handshake plus the control-word / select-strobe link to the decoder.
// master = issuer side, slave = command source and decoder side.
interface cu_cmd_issuer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_sel;
    logic       cmd_mode;
    logic       ctl_a;
    logic       ctl_b;
    logic       ctl_c;
    logic       ctl_d;
    logic       ctl_e;
    logic       ctl_f;
    logic       ctl_o;
    logic [3:0] dec_ack;

    modport master (
        input  cmd_valid, cmd_op, cmd_sel, cmd_mode, dec_ack,
        output cmd_ready, ctl_a, ctl_b, ctl_c, ctl_d, ctl_e, ctl_f, ctl_o
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_sel, cmd_mode, dec_ack,
        input  cmd_ready, ctl_a, ctl_b, ctl_c, ctl_d, ctl_e, ctl_f, ctl_o
    );
endinterface

// File: rtl/cu_issue_fifo.sv
// Synchronous show-ahead FIFO, DEPTH entries (power of two) of W bits.
// Latency: pushed data visible on rd_dat the cycle after push.
// Backpressure: push ignored when full, pop ignored when empty.
module cu_issue_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wr_dat,
    input  logic         pop,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/cu_cmd_issuer.sv
// Queues commands and drives each as a registered control word to the decoder; SEL waits for its one-hot ack.
// Latency: word on ctl_* one cycle after pop; SEL retires >=3 cycles after pop; one idle-word GAP cycle between commands.
// Backpressure: cmd_ready drops while the FIFO is full. CU_ACK_TIMEOUT_EN adds a SEL ack timeout of TO_CYC.
module cu_cmd_issuer
    import cu_issue_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int HOLD_CYC = 2,
    parameter int TO_CYC   = 15
) (
    input  logic             clk,
    input  logic             rst,
    cu_cmd_issuer_if.master  bus,
    output logic             busy,
    output logic             err,
    input  logic             err_clr
);
    localparam int CNT_TOP = (HOLD_CYC > TO_CYC) ? HOLD_CYC : TO_CYC;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

    state_e          state_q;
    state_e          state_d;
    ctl_word_t       word_q;
    op_e             op_q;
    logic [1:0]      sel_q;
    logic [CNT_W-1:0] cnt_q;

    cmd_t            fifo_wr;
    cmd_t            fifo_rd;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;

    logic            ack_hit;
    logic            ack_bad;
    logic            timeout;
    logic            hold_done;
    logic            word_clr;
    logic            cnt_clr;
    logic            cnt_inc;
    logic            new_err;

    assign fifo_wr       = {bus.cmd_op, bus.cmd_sel, bus.cmd_mode};
    assign fifo_push     = bus.cmd_valid && !fifo_full;
    assign bus.cmd_ready = !fifo_full;

    cu_issue_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(cmd_t))
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (fifo_push),
        .wr_dat (fifo_wr),
        .pop    (fifo_pop),
        .rd_dat (fifo_rd),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign ack_hit   = (bus.dec_ack == (4'b0001 << sel_q));
    assign ack_bad   = (bus.dec_ack != 4'b0000) && !ack_hit;
    assign hold_done = (cnt_q == HOLD_LAST);
`ifdef CU_ACK_TIMEOUT_EN
    assign timeout   = (cnt_q == CNT_W'(TO_CYC));
`else
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_SETUP;
            ST_SETUP: state_d = ST_WAIT;
            ST_WAIT: begin
                if (op_q == OP_SEL) begin
                    if (ack_hit || ack_bad || timeout) state_d = ST_GAP;
                end else if (hold_done) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_pop = 1'b0;
        word_clr = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        new_err  = 1'b0;
        case (state_q)
            ST_IDLE:  fifo_pop = !fifo_empty;
            ST_SETUP: cnt_clr  = 1'b1;
            ST_WAIT: begin
                cnt_inc = 1'b1;
                if (op_q == OP_SEL) begin
                    // A matching ack beats a simultaneous timeout.
                    new_err  = !ack_hit && (ack_bad || timeout);
                    word_clr = ack_hit || ack_bad || timeout;
                end else begin
                    word_clr = hold_done;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= IDLE_WORD;
            op_q   <= OP_NOP;
            sel_q  <= 2'b00;
            cnt_q  <= '0;
            err    <= 1'b0;
        end else begin
            if (fifo_pop) begin
                word_q <= encode(fifo_rd.op, fifo_rd.sel, fifo_rd.mode);
                op_q   <= fifo_rd.op;
                sel_q  <= fifo_rd.sel;
            end else if (word_clr) begin
                word_q <= IDLE_WORD;
            end

            if (cnt_clr)                        cnt_q <= '0;
            else if (cnt_inc && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);

            if (new_err)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

    assign busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign bus.ctl_a = word_q.a;
    assign bus.ctl_b = word_q.b;
    assign bus.ctl_c = word_q.c;
    assign bus.ctl_d = word_q.d;
    assign bus.ctl_e = word_q.e;
    assign bus.ctl_f = word_q.f;
    assign bus.ctl_o = word_q.o;
endmodule

// File: tb/tb_cu_cmd_issuer.sv
// Directed bench for cu_cmd_issuer: inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_cu_cmd_issuer;
    localparam logic [1:0] NOP  = 2'd0;
    localparam logic [1:0] SEL  = 2'd1;
    localparam logic [1:0] PASS = 2'd2;
    localparam logic [1:0] GATE = 2'd3;

    localparam logic [6:0] W_IDLE  = 7'b0001000;
    localparam logic [6:0] W_SEL0  = 7'b0000010;
    localparam logic [6:0] W_SEL1  = 7'b1000010;
    localparam logic [6:0] W_SEL2  = 7'b0100010;
    localparam logic [6:0] W_SEL3  = 7'b1100010;
    localparam logic [6:0] W_PASS0 = 7'b0010100;
    localparam logic [6:0] W_PASS1 = 7'b0010101;
    localparam logic [6:0] W_GATE  = 7'b0000111;

    logic clk = 1'b0;
    logic rst;
    logic err_clr;
    logic busy;
    logic err;
    logic [6:0] ctl_w;
    int n_cmp = 0;
    int n_bad = 0;

    cu_cmd_issuer_if bus ();

    cu_cmd_issuer #(
        .DEPTH    (4),
        .HOLD_CYC (2),
        .TO_CYC   (15)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .err     (err),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    assign ctl_w = {bus.ctl_a, bus.ctl_b, bus.ctl_c, bus.ctl_d, bus.ctl_e, bus.ctl_f, bus.ctl_o};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Offers one command for one edge; the FIFO must have room.
    task automatic push(input logic [1:0] op, input logic [1:0] sel, input logic mode);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_sel   = sel;
        bus.cmd_mode  = mode;
        chk1("push_ready", bus.cmd_ready, 1'b1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] exp_words [4];
        exp_words[0] = W_GATE;
        exp_words[1] = W_PASS0;
        exp_words[2] = W_PASS1;
        exp_words[3] = W_IDLE;

        rst = 1'b1; err_clr = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = NOP; bus.cmd_sel = 2'd0; bus.cmd_mode = 1'b0;
        bus.dec_ack = 4'b0000;
        tick(); tick();
        chk7("init_ctl", ctl_w, W_IDLE);
        chk1("init_busy", busy, 1'b0);
        chk1("init_ready", bus.cmd_ready, 1'b1);
        chk1("init_err", err, 1'b0);
        rst = 1'b0;

        // Reset while a SEL waits and three NOPs are queued.
        push(SEL, 2'd0, 1'b0);
        bus.cmd_valid = 1'b1; bus.cmd_op = NOP;
        tick(); tick(); tick();
        bus.cmd_valid = 1'b0;
        chk7("midcmd_ctl", ctl_w, W_SEL0);
        chk1("midcmd_busy", busy, 1'b1);
        rst = 1'b1;
        tick(); tick();
        chk7("rst_ctl", ctl_w, W_IDLE);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ready", bus.cmd_ready, 1'b1);
        rst = 1'b0;
        tick();
        chk1("rst_fifo_empty", busy, 1'b0);
        chk7("rst_ctl_after", ctl_w, W_IDLE);

        // SEL sel=2; a mismatching ack outside WAIT must be ignored.
        bus.dec_ack = 4'b0001;
        push(SEL, 2'd2, 1'b0);
        tick();
        chk7("sel2_setup_word", ctl_w, W_SEL2);
        tick();
        chk7("sel2_wait_word", ctl_w, W_SEL2);
        chk1("sel2_ack_ignored", err, 1'b0);
        bus.dec_ack = 4'b0100;
        tick();
        bus.dec_ack = 4'b0000;
        chk7("sel2_gap_word", ctl_w, W_IDLE);
        chk1("sel2_gap_busy", busy, 1'b1);
        chk1("sel2_err", err, 1'b0);
        tick();
        chk1("sel2_idle_busy", busy, 1'b0);

        // PASS mode=1: SETUP + 2 WAIT cycles of the word, then idle.
        push(PASS, 2'd0, 1'b1);
        tick();
        chk7("pass_setup", ctl_w, W_PASS1);
        tick();
        chk7("pass_wait0", ctl_w, W_PASS1);
        tick();
        chk7("pass_wait1", ctl_w, W_PASS1);
        tick();
        chk7("pass_gap", ctl_w, W_IDLE);
        tick();
        chk1("pass_done_busy", busy, 1'b0);
        chk1("pass_err", err, 1'b0);

        // Fill the FIFO behind a SEL that is waiting for its ack.
        push(SEL, 2'd0, 1'b0);
        tick(); tick();
        bus.cmd_valid = 1'b1;
        bus.cmd_op = GATE; bus.cmd_sel = 2'd0; bus.cmd_mode = 1'b0;
        tick();
        bus.cmd_op = PASS; bus.cmd_mode = 1'b0;
        tick();
        bus.cmd_op = PASS; bus.cmd_mode = 1'b1;
        tick();
        bus.cmd_op = NOP; bus.cmd_mode = 1'b0;
        chk1("fill_ready_3", bus.cmd_ready, 1'b1);
        tick();
        chk1("full_ready", bus.cmd_ready, 1'b0);
        bus.dec_ack = 4'b0001;
        tick();
        bus.dec_ack = 4'b0000;
        chk1("full_ready_gap", bus.cmd_ready, 1'b0);
        tick();
        chk1("full_ready_idle", bus.cmd_ready, 1'b0);
        tick();
        chk1("ready_after_pop", bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk7($sformatf("order_word%0d", i), ctl_w, exp_words[i]);
            tick(); tick(); tick();
            chk7($sformatf("order_gap%0d", i), ctl_w, W_IDLE);
            tick(); tick();
        end
        chk1("fill_done_busy", busy, 1'b0);
        chk1("fill_err", err, 1'b0);

        // SEL sel=1 answered with the wrong strobe.
        push(SEL, 2'd1, 1'b0);
        tick();
        chk7("bad_setup_word", ctl_w, W_SEL1);
        tick();
        bus.dec_ack = 4'b1000;
        tick();
        bus.dec_ack = 4'b0000;
        chk1("bad_err_set", err, 1'b1);
        chk7("bad_retired", ctl_w, W_IDLE);
        tick();
        chk1("bad_err_sticky", err, 1'b1);
        chk1("bad_idle_busy", busy, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk1("err_cleared", err, 1'b0);

        // Clear and a new error in the same cycle: the error wins.
        push(SEL, 2'd3, 1'b0);
        tick();
        chk7("sel3_setup_word", ctl_w, W_SEL3);
        tick();
        bus.dec_ack = 4'b0001;
        err_clr = 1'b1;
        tick();
        bus.dec_ack = 4'b0000;
        err_clr = 1'b0;
        chk1("clr_vs_err", err, 1'b1);
        tick();
        chk1("clr_vs_err_hold", err, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk1("err_cleared2", err, 1'b0);

        // SEL with no ack at all.
        push(SEL, 2'd2, 1'b0);
        tick(); tick();
`ifdef CU_ACK_TIMEOUT_EN
        repeat (15) tick();
        chk1("to_before_err", err, 1'b0);
        chk1("to_before_busy", busy, 1'b1);
        tick();
        chk1("to_err", err, 1'b1);
        chk7("to_gap_word", ctl_w, W_IDLE);
        tick();
        chk1("to_idle_busy", busy, 1'b0);
`else
        for (int i = 0; i < 100; i++) begin
            chk1($sformatf("noack_busy%0d", i), busy, 1'b1);
            tick();
        end
        chk7("noack_word", ctl_w, W_SEL2);
        chk1("noack_err", err, 1'b0);
        bus.dec_ack = 4'b0100;
        tick();
        bus.dec_ack = 4'b0000;
        chk7("noack_release_gap", ctl_w, W_IDLE);
        tick();
        chk1("noack_release_busy", busy, 1'b0);
        chk1("noack_release_err", err, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
